// File: rtl/mask_random_source_if.sv
// Fresh-randomness stream: seed load in, (r, p) mask words out with valid/ready.
interface mask_random_source_if #(
    parameter int NQ        = 3,
    parameter int BIT_WIDTH = 1
);
    typedef logic [BIT_WIDTH-1:0] elem_t;

    logic [31:0]     in_seed;
    logic            in_seed_valid;
    logic            out_seed_ready;
    logic            out_seed_error;
    elem_t [NQ-1:0]  out_r;
    elem_t [NQ-1:0]  out_p;
    logic            out_valid;
    logic            in_ready;

    modport master (
        input  in_seed, in_seed_valid, in_ready,
        output out_seed_ready, out_seed_error, out_r, out_p, out_valid
    );

    modport slave (
        output in_seed, in_seed_valid, in_ready,
        input  out_seed_ready, out_seed_error, out_r, out_p, out_valid
    );
endinterface

// File: rtl/mask_random_source.sv
// Seeded 32-bit Galois LFSR emitting one registered (r, p) mask pair per handshake; first word WARMUP_WORDS+1 cycles after seeding.
// Consumer backpressure (in_ready=0) freezes word and LFSR state; seed load always accepted and overrides a concurrent fire.
module mask_random_source #(
    parameter int          NUM_SHARES   = 3,
    parameter int          BIT_WIDTH    = 1,
    parameter int          WARMUP_WORDS = 16,
    parameter logic [31:0] TAPS         = 32'h80200003
) (
    input  logic                    in_clock,
    input  logic                    in_reset,
    mask_random_source_if.master    bus
);
    localparam int NQ       = NUM_SHARES * (NUM_SHARES - 1) / 2;
    localparam int HALF     = NQ * BIT_WIDTH;
    localparam int OUT_BITS = 2 * HALF;
    localparam int CW       = (WARMUP_WORDS > 0) ? $clog2(WARMUP_WORDS + 1) : 1;
    localparam logic [CW-1:0] WARM_INIT = CW'(WARMUP_WORDS);

    typedef enum logic [1:0] {ST_UNSEEDED, ST_WARMUP, ST_RUN} fsm_t;

    typedef struct packed {
        logic [OUT_BITS-1:0] word;
        logic [31:0]         state;
    } gen_t;

    // OUT_BITS LFSR steps unrolled; bit i of the word is the i-th bit shifted out.
    function automatic gen_t gen_word(input logic [31:0] seed);
        gen_t        g;
        logic [31:0] s;
        s      = seed;
        g.word = '0;
        for (int i = 0; i < OUT_BITS; i++) begin
            g.word[i] = s[0];
            s = (s >> 1) ^ (s[0] ? TAPS : 32'h0);
        end
        g.state = s;
        return g;
    endfunction

    fsm_t                r_fsm;
    logic [31:0]         r_state;
    logic [OUT_BITS-1:0] r_word;
    logic [CW-1:0]       r_cnt;
    logic                r_valid;
    logic                r_seed_err;

    fsm_t                w_fsm_nxt;
    logic [CW-1:0]       w_cnt_nxt;
    logic                w_gen_en;
    logic [31:0]         w_gen_src;
    gen_t                w_gen;
    logic                w_seed_ok;
    logic                w_seed_zero;

    assign w_seed_ok   = bus.in_seed_valid && (bus.in_seed != 32'h0);
    assign w_seed_zero = bus.in_seed_valid && (bus.in_seed == 32'h0);

    always_comb begin
        w_fsm_nxt = r_fsm;
        w_cnt_nxt = r_cnt;
        w_gen_en  = 1'b0;
        w_gen_src = r_state;
        case (r_fsm)
            ST_WARMUP: begin
                w_gen_en  = 1'b1;
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt <= CW'(1)) begin
                    w_fsm_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.in_ready) begin
                    w_gen_en = 1'b1;
                end
            end
            default: ;
        endcase
        // A valid seed beats warm-up progress and any concurrent consumer fire.
        if (w_seed_ok) begin
            w_gen_en  = 1'b1;
            w_gen_src = bus.in_seed;
            w_cnt_nxt = WARM_INIT;
            w_fsm_nxt = (WARMUP_WORDS > 0) ? ST_WARMUP : ST_RUN;
        end
    end

    assign w_gen = gen_word(w_gen_src);

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            r_fsm      <= ST_UNSEEDED;
            r_state    <= 32'h0;
            r_word     <= '0;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_seed_err <= 1'b0;
        end else begin
            r_fsm      <= w_fsm_nxt;
            r_cnt      <= w_cnt_nxt;
            r_valid    <= (w_fsm_nxt == ST_RUN);
            r_seed_err <= w_seed_zero;
            if (w_gen_en) begin
                r_word  <= w_gen.word;
                r_state <= w_gen.state;
            end
        end
    end

    assign bus.out_seed_ready = 1'b1;
    assign bus.out_seed_error = r_seed_err;
    assign bus.out_valid      = r_valid;
    assign bus.out_r          = r_word[HALF-1:0];
    assign bus.out_p          = r_word[OUT_BITS-1:HALF];
endmodule

// File: tb/tb_mask_random_source.sv
// Bench for mask_random_source: a no-warm-up pair-share instance and a three-share instance with 16-word warm-up.
module tb_mask_random_source;
    localparam logic [31:0] TAPS = 32'h80200003;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mask_random_source_if #(.NQ(1), .BIT_WIDTH(1)) ifa ();
    mask_random_source_if #(.NQ(3), .BIT_WIDTH(1)) ifb ();

    mask_random_source #(.NUM_SHARES(2), .BIT_WIDTH(1), .WARMUP_WORDS(0), .TAPS(TAPS)) dut_a (
        .in_clock (clk),
        .in_reset (rst),
        .bus      (ifa.master)
    );

    mask_random_source #(.NUM_SHARES(3), .BIT_WIDTH(1), .WARMUP_WORDS(16), .TAPS(TAPS)) dut_b (
        .in_clock (clk),
        .in_reset (rst),
        .bus      (ifb.master)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference: the mask stream is just the LFSR bit sequence cut into words.
    logic [31:0] ma_st, mb_st;
    logic [1:0]  ma_w;
    logic [5:0]  mb_w;

    function automatic logic [63:0] take_bits(inout logic [31:0] st, input int n);
        logic [63:0] w;
        logic        b;
        w = '0;
        for (int i = 0; i < n; i++) begin
            b    = st[0];
            w[i] = b;
            st   = (st >> 1) ^ (b ? TAPS : 32'h0);
        end
        return w;
    endfunction

    function automatic void ma_next();
        logic [63:0] w;
        w    = take_bits(ma_st, 2);
        ma_w = w[1:0];
    endfunction

    function automatic void mb_next();
        logic [63:0] w;
        w    = take_bits(mb_st, 6);
        mb_w = w[5:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifa.in_seed = 32'h0; ifa.in_seed_valid = 1'b0; ifa.in_ready = 1'b0;
        ifb.in_seed = 32'h0; ifb.in_seed_valid = 1'b0; ifb.in_ready = 1'b0;
        repeat (3) tick();
        vectors++;
        if (ifa.out_valid !== 1'b0 || ifa.out_seed_ready !== 1'b1 || {ifa.out_p, ifa.out_r} !== 2'b0 || ifa.out_seed_error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_a: valid=%b rdy=%b word=%b err=%b, want 0 1 00 0", ifa.out_valid, ifa.out_seed_ready, {ifa.out_p, ifa.out_r}, ifa.out_seed_error);
        end
        vectors++;
        if (ifb.out_valid !== 1'b0 || ifb.out_seed_ready !== 1'b1 || {ifb.out_p, ifb.out_r} !== 6'b0 || ifb.out_seed_error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_b: valid=%b rdy=%b word=%b err=%b, want 0 1 000000 0", ifb.out_valid, ifb.out_seed_ready, {ifb.out_p, ifb.out_r}, ifb.out_seed_error);
        end
        rst = 1'b0;
        ifa.in_ready = 1'b1;
        ifb.in_ready = 1'b1;
        repeat (4) tick();
        vectors++;
        if (ifa.out_valid !== 1'b0 || {ifa.out_p, ifa.out_r} !== 2'b0 || ifa.out_seed_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL unseeded_a: valid=%b word=%b rdy=%b, want 0 00 1", ifa.out_valid, {ifa.out_p, ifa.out_r}, ifa.out_seed_ready);
        end
        vectors++;
        if (ifb.out_valid !== 1'b0 || {ifb.out_p, ifb.out_r} !== 6'b0) begin
            miscompares++;
            $display("FAIL unseeded_b: valid=%b word=%b, want 0 000000", ifb.out_valid, {ifb.out_p, ifb.out_r});
        end
        ifa.in_ready = 1'b0;
        ifb.in_ready = 1'b0;
    endtask

    task automatic test_seed_one();
        ifa.in_seed = 32'h1; ifa.in_seed_valid = 1'b1;
        tick();
        ifa.in_seed_valid = 1'b0;
        ma_st = 32'h1;
        ma_next();
        vectors++;
        if (ifa.out_valid !== 1'b1 || ifa.out_r !== 1'b1 || ifa.out_p !== 1'b1) begin
            miscompares++;
            $display("FAIL seed1_first: valid=%b r=%b p=%b, want 1 1 1", ifa.out_valid, ifa.out_r, ifa.out_p);
        end
        ifa.in_ready = 1'b1;
        tick();
        ifa.in_ready = 1'b0;
        ma_next();
        vectors++;
        if (ifa.out_valid !== 1'b1 || ifa.out_r !== 1'b0 || ifa.out_p !== 1'b1) begin
            miscompares++;
            $display("FAIL seed1_fire: valid=%b r=%b p=%b, want 1 0 1", ifa.out_valid, ifa.out_r, ifa.out_p);
        end
        repeat (2) tick();
        vectors++;
        if ({ifa.out_p, ifa.out_r} !== ma_w) begin
            miscompares++;
            $display("FAIL seed1_hold: word=%b, want %b", {ifa.out_p, ifa.out_r}, ma_w);
        end
    endtask

    task automatic test_a_random();
        logic        sv, rdy, fire, err_exp;
        logic [31:0] seed;
        for (int i = 0; i < 200; i++) begin
            sv   = ($urandom_range(0, 9) == 0);
            seed = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            rdy  = 1'($urandom_range(0, 1));
            ifa.in_seed = seed; ifa.in_seed_valid = sv; ifa.in_ready = rdy;
            fire = ifa.out_valid && rdy;
            tick();
            if (sv && seed != 32'h0) begin
                ma_st = seed;
                ma_next();
            end else if (fire) begin
                ma_next();
            end
            err_exp = sv && (seed == 32'h0);
            vectors++;
            if (ifa.out_valid !== 1'b1 || {ifa.out_p, ifa.out_r} !== ma_w || ifa.out_seed_error !== err_exp) begin
                miscompares++;
                $display("FAIL a_random[%0d]: valid=%b word=%b err=%b, want 1 %b %b", i, ifa.out_valid, {ifa.out_p, ifa.out_r}, ifa.out_seed_error, ma_w, err_exp);
            end
        end
        ifa.in_seed_valid = 1'b0;
        ifa.in_ready = 1'b0;
    endtask

    task automatic test_warmup();
        int   lat;
        logic rdy, fire;
        ifb.in_ready = 1'b0;
        ifb.in_seed = 32'hACE1; ifb.in_seed_valid = 1'b1;
        tick();
        ifb.in_seed_valid = 1'b0;
        mb_st = 32'hACE1;
        repeat (17) mb_next();
        // Edges after the accept edge; 16 means valid in the 17th cycle.
        lat = 0;
        while (!ifb.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat !== 16) begin
            miscompares++;
            $display("FAIL warmup_latency: got %0d edges, want 16", lat);
        end
        vectors++;
        if ({ifb.out_p, ifb.out_r} !== mb_w) begin
            miscompares++;
            $display("FAIL warmup_first_word: word=%b, want %b", {ifb.out_p, ifb.out_r}, mb_w);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (ifb.out_valid !== 1'b1 || {ifb.out_p, ifb.out_r} !== mb_w) begin
                miscompares++;
                $display("FAIL freeze[%0d]: valid=%b word=%b, want 1 %b", i, ifb.out_valid, {ifb.out_p, ifb.out_r}, mb_w);
            end
        end
        for (int i = 0; i < 60; i++) begin
            rdy = 1'($urandom_range(0, 1));
            ifb.in_ready = rdy;
            fire = ifb.out_valid && rdy;
            tick();
            if (fire) mb_next();
            vectors++;
            if (ifb.out_valid !== 1'b1 || {ifb.out_p, ifb.out_r} !== mb_w) begin
                miscompares++;
                $display("FAIL b_random[%0d]: valid=%b word=%b, want 1 %b", i, ifb.out_valid, {ifb.out_p, ifb.out_r}, mb_w);
            end
        end
        ifb.in_ready = 1'b0;
    endtask

    task automatic test_zero_seed();
        ifb.in_seed = 32'h0; ifb.in_seed_valid = 1'b1; ifb.in_ready = 1'b1;
        tick();
        ifb.in_seed_valid = 1'b0; ifb.in_ready = 1'b0;
        mb_next();
        vectors++;
        if (ifb.out_seed_error !== 1'b1 || ifb.out_valid !== 1'b1 || {ifb.out_p, ifb.out_r} !== mb_w) begin
            miscompares++;
            $display("FAIL zero_seed: err=%b valid=%b word=%b, want 1 1 %b", ifb.out_seed_error, ifb.out_valid, {ifb.out_p, ifb.out_r}, mb_w);
        end
        tick();
        vectors++;
        if (ifb.out_seed_error !== 1'b0 || {ifb.out_p, ifb.out_r} !== mb_w) begin
            miscompares++;
            $display("FAIL zero_seed_pulse: err=%b word=%b, want 0 %b", ifb.out_seed_error, {ifb.out_p, ifb.out_r}, mb_w);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        ifb.in_ready = 1'b1;
        ifb.in_seed = 32'h1; ifb.in_seed_valid = 1'b1;
        tick();
        ifb.in_seed_valid = 1'b0;
        mb_st = 32'h1;
        repeat (17) mb_next();
        vectors++;
        if (ifb.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reseed_fire_valid: valid=%b, want 0", ifb.out_valid);
        end
        lat = 0;
        while (!ifb.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat !== 16 || {ifb.out_p, ifb.out_r} !== mb_w) begin
            miscompares++;
            $display("FAIL reseed_first: lat=%0d word=%b, want 16 %b", lat, {ifb.out_p, ifb.out_r}, mb_w);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            mb_next();
            vectors++;
            if (ifb.out_valid !== 1'b1 || {ifb.out_p, ifb.out_r} !== mb_w) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: valid=%b word=%b, want 1 %b", i, ifb.out_valid, {ifb.out_p, ifb.out_r}, mb_w);
            end
        end
        ifb.in_ready = 1'b0;
    endtask

    task automatic test_reset_mid_warmup();
        int          lat;
        logic [31:0] seed;
        ifb.in_ready = 1'b0;
        seed = $urandom | 32'h1;
        ifb.in_seed = seed; ifb.in_seed_valid = 1'b1;
        tick();
        ifb.in_seed_valid = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        vectors++;
        if (ifb.out_valid !== 1'b0 || {ifb.out_p, ifb.out_r} !== 6'b0 || ifb.out_seed_error !== 1'b0 || ifb.out_seed_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset: valid=%b word=%b err=%b rdy=%b, want 0 000000 0 1", ifb.out_valid, {ifb.out_p, ifb.out_r}, ifb.out_seed_error, ifb.out_seed_ready);
        end
        rst = 1'b0;
        ifb.in_ready = 1'b1;
        repeat (20) tick();
        vectors++;
        if (ifb.out_valid !== 1'b0 || {ifb.out_p, ifb.out_r} !== 6'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: valid=%b word=%b, want 0 000000", ifb.out_valid, {ifb.out_p, ifb.out_r});
        end
        ifb.in_ready = 1'b0;
        ifb.in_seed = 32'h12345678; ifb.in_seed_valid = 1'b1;
        tick();
        ifb.in_seed_valid = 1'b0;
        mb_st = 32'h12345678;
        repeat (17) mb_next();
        lat = 0;
        while (!ifb.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat !== 16 || {ifb.out_p, ifb.out_r} !== mb_w) begin
            miscompares++;
            $display("FAIL rewarm: lat=%0d word=%b, want 16 %b", lat, {ifb.out_p, ifb.out_r}, mb_w);
        end
    endtask

    initial begin
        test_reset();
        test_seed_one();
        test_a_random();
        test_warmup();
        test_zero_seed();
        test_back_to_back();
        test_reset_mid_warmup();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
